// File: rtl/dist_pair_scheduler_pkg.sv
// Shared encodings and defaults for the distance-calculator slice:
// scheduler FSM states and datapath widths.
package dist_pair_scheduler_pkg;

    localparam int DPS_WORD_WIDTH = 8;
    localparam int DPS_CNT_WIDTH  = 16;
    localparam int DPS_TIMEOUT    = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_FIN   = 3'd5
    } dps_state_e;

endpackage

// File: rtl/dist_pair_scheduler_if.sv
// Calculator request/response and result-stream signals of the pair scheduler.
// master = scheduler side, slave = calculator plus result consumer.
interface dist_pair_scheduler_if
    import dist_pair_scheduler_pkg::*;
#(
    parameter int WORD_WIDTH = DPS_WORD_WIDTH
);
    logic                  calc_en;
    logic [WORD_WIDTH-1:0] calc_idx1;
    logic [WORD_WIDTH-1:0] calc_idx2;
    logic                  calc_clear;
    logic                  calc_valid;
    logic [WORD_WIDTH-1:0] calc_dist;
    logic                  calc_overflow;
    logic                  res_valid;
    logic                  res_ready;
    logic [WORD_WIDTH-1:0] res_idx1;
    logic [WORD_WIDTH-1:0] res_idx2;
    logic [WORD_WIDTH-1:0] res_dist;
    logic                  res_overflow;

    modport master (
        output calc_en, calc_idx1, calc_idx2, calc_clear,
        output res_valid, res_idx1, res_idx2, res_dist, res_overflow,
        input  calc_valid, calc_dist, calc_overflow, res_ready
    );

    modport slave (
        input  calc_en, calc_idx1, calc_idx2, calc_clear,
        input  res_valid, res_idx1, res_idx2, res_dist, res_overflow,
        output calc_valid, calc_dist, calc_overflow, res_ready
    );
endinterface

// File: rtl/dist_pair_index_gen.sv
// Walks ordered index pairs idx1 < idx2 < n in row-major order.
// last flags that the current pair is the final one of the sweep.
module dist_pair_index_gen
    import dist_pair_scheduler_pkg::*;
#(
    parameter int WORD_WIDTH = DPS_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  advance,
    input  logic [WORD_WIDTH-1:0] n,
    output logic [WORD_WIDTH-1:0] idx1,
    output logic [WORD_WIDTH-1:0] idx2,
    output logic                  last
);
    logic [WORD_WIDTH:0] i2_p1;
    logic [WORD_WIDTH:0] i1_p2;
    logic [WORD_WIDTH:0] n_x;
    logic                step2;

    // One extra bit so the compares against n never wrap
    assign n_x   = {1'b0, n};
    assign i2_p1 = {1'b0, idx2} + (WORD_WIDTH+1)'(1);
    assign i1_p2 = {1'b0, idx1} + (WORD_WIDTH+1)'(2);
    assign step2 = i2_p1 < n_x;
    assign last  = !step2 && !(i1_p2 < n_x);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx1 <= '0;
            idx2 <= '0;
        end else if (load) begin
            idx1 <= '0;
            idx2 <= WORD_WIDTH'(1);
        end else if (advance) begin
            if (step2) begin
                idx2 <= i2_p1[WORD_WIDTH-1:0];
            end else begin
                idx1 <= idx1 + WORD_WIDTH'(1);
                idx2 <= i1_p2[WORD_WIDTH-1:0];
            end
        end
    end
endmodule

// File: rtl/dist_pair_scheduler.sv
// Sequences the distance calculator over every index pair of one kernel
// and streams tagged results downstream.
module dist_pair_scheduler
    import dist_pair_scheduler_pkg::*;
#(
    parameter int WORD_WIDTH = DPS_WORD_WIDTH,
    parameter int CNT_WIDTH  = DPS_CNT_WIDTH,
    parameter int TIMEOUT    = DPS_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WORD_WIDTH-1:0] cfg_ke_size,
    dist_pair_scheduler_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err,
    output logic [CNT_WIDTH-1:0]  pair_cnt
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    dps_state_e            state_q;
    dps_state_e            state_d;
    logic [WORD_WIDTH-1:0] n_q;
    logic [WD_W-1:0]       wdog_q;
    logic [WORD_WIDTH-1:0] idx1;
    logic [WORD_WIDTH-1:0] idx2;
    logic                  idx_last;
    logic                  idx_load;
    logic                  idx_adv;
    logic                  latch_cfg;
    logic                  capture;
    logic                  clr_set;
    logic                  done_set;
    logic                  to_set;
    logic                  cnt_inc;
    logic                  wd_clr;
    logic                  wd_inc;
    logic                  wd_hit;

    dist_pair_index_gen #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_idx (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (idx_load),
        .advance(idx_adv),
        .n      (n_q),
        .idx1   (idx1),
        .idx2   (idx2),
        .last   (idx_last)
    );

    assign wd_hit        = wdog_q == WD_W'(TIMEOUT - 1);
    assign busy          = state_q != ST_IDLE;
    assign bus.calc_en   = state_q == ST_ISSUE;
    assign bus.res_valid = state_q == ST_EMIT;
    assign bus.calc_idx1 = idx1;
    assign bus.calc_idx2 = idx2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        idx_load  = 1'b0;
        idx_adv   = 1'b0;
        latch_cfg = 1'b0;
        capture   = 1'b0;
        clr_set   = 1'b0;
        done_set  = 1'b0;
        to_set    = 1'b0;
        cnt_inc   = 1'b0;
        wd_clr    = 1'b0;
        wd_inc    = 1'b0;
        if (busy && abort) begin
            state_d = ST_IDLE;
            clr_set = state_q == ST_WAIT;
        end else begin
            unique case (state_q)
                ST_IDLE: if (start) begin
                    latch_cfg = 1'b1;
                    if (cfg_ke_size < WORD_WIDTH'(2)) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_load = 1'b1;
                        state_d  = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wd_clr  = 1'b1;
                    state_d = ST_WAIT;
                end
                // A result arriving on the timeout cycle still wins
                ST_WAIT: if (bus.calc_valid) begin
                    capture = 1'b1;
                    clr_set = 1'b1;
                    state_d = ST_EMIT;
                end else if (wd_hit) begin
                    to_set  = 1'b1;
                    clr_set = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    wd_inc = 1'b1;
                end
                ST_EMIT: if (bus.res_ready) begin
                    cnt_inc = 1'b1;
                    state_d = ST_NEXT;
                end
                ST_NEXT: if (idx_last) begin
                    state_d = ST_FIN;
                end else begin
                    idx_adv = 1'b1;
                    state_d = ST_ISSUE;
                end
                ST_FIN: begin
                    done_set = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_q              <= '0;
            wdog_q           <= '0;
            pair_cnt         <= '0;
            timeout_err      <= 1'b0;
            done             <= 1'b0;
            bus.calc_clear   <= 1'b0;
            bus.res_idx1     <= '0;
            bus.res_idx2     <= '0;
            bus.res_dist     <= '0;
            bus.res_overflow <= 1'b0;
        end else begin
            done           <= done_set;
            bus.calc_clear <= clr_set;
            if (latch_cfg) begin
                n_q         <= cfg_ke_size;
                pair_cnt    <= '0;
                timeout_err <= 1'b0;
            end
            if (to_set) timeout_err <= 1'b1;
            if (cnt_inc && pair_cnt != '1) begin
                pair_cnt <= pair_cnt + CNT_WIDTH'(1);
            end
            if (wd_clr)      wdog_q <= '0;
            else if (wd_inc) wdog_q <= wdog_q + WD_W'(1);
            if (capture) begin
                bus.res_idx1     <= idx1;
                bus.res_idx2     <= idx2;
                bus.res_dist     <= bus.calc_dist;
                bus.res_overflow <= bus.calc_overflow;
            end
        end
    end
endmodule

// File: tb/tb_dist_pair_scheduler.sv
// Randomized bench for dist_pair_scheduler: a responder plays the
// calculator, a pair-list model and scoreboard judge the result stream.
module tb_dist_pair_scheduler;
    import dist_pair_scheduler_pkg::*;

    localparam int W   = 8;
    localparam int CW  = 16;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [W-1:0]  cfg_ke_size;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic [CW-1:0] pair_cnt;

    dist_pair_scheduler_if #(.WORD_WIDTH(W)) bus ();

    dist_pair_scheduler #(
        .WORD_WIDTH(W),
        .CNT_WIDTH (CW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .cfg_ke_size(cfg_ke_size),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .timeout_err(timeout_err),
        .pair_cnt   (pair_cnt)
    );

    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    int cyc;
    int n_done;
    int n_clr;
    int n_stall;
    int stall_err;
    int last_en_cyc;
    int last_clr_cyc;
    int last_done_cyc;
    logic [15:0] en_q[$];
    logic [15:0] res_q[$];
    logic [8:0]  rdat_q[$];
    logic [8:0]  sent_q[$];
    bit   rsp_pend;
    bit   rsp_hang;
    int   rsp_cnt;
    int   lat_lo;
    int   lat_hi;
    int   rmode;
    int   stall_at;
    int   stall_left;
    bit   prev_stall;
    logic [24:0] prev_res;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: calculator responder, result consumer and event log
    task automatic tick();
        logic [24:0] cur;
        logic [8:0]  d;
        logic        rdy;
        @(negedge clk);
        cyc++;
        if (!reset_n) begin
            rsp_pend       = 1'b0;
            prev_stall     = 1'b0;
            bus.calc_valid = 1'b0;
            return;
        end
        if (bus.calc_clear) begin
            n_clr++;
            last_clr_cyc   = cyc;
            rsp_pend       = 1'b0;
            bus.calc_valid = 1'b0;
        end else if (rsp_pend && !rsp_hang) begin
            if (rsp_cnt == 0) begin
                d                 = 9'($urandom);
                bus.calc_dist     = d[8:1];
                bus.calc_overflow = d[0];
                bus.calc_valid    = 1'b1;
                sent_q.push_back(d);
                rsp_pend = 1'b0;
            end else begin
                rsp_cnt--;
            end
        end
        if (bus.calc_en) begin
            en_q.push_back({bus.calc_idx1, bus.calc_idx2});
            last_en_cyc = cyc;
            rsp_pend    = 1'b1;
            rsp_cnt     = $urandom_range(lat_hi, lat_lo);
        end
        if (done) begin
            n_done++;
            last_done_cyc = cyc;
        end
        cur = {bus.res_idx1, bus.res_idx2, bus.res_dist, bus.res_overflow};
        if (prev_stall && (!bus.res_valid || cur !== prev_res)) stall_err++;
        if (rmode == 0)      rdy = 1'b1;
        else if (rmode == 1) rdy = $urandom_range(3, 0) != 0;
        else if (rmode == 2) rdy = !(bus.res_valid && res_q.size() == stall_at
                                     && stall_left > 0);
        else                 rdy = 1'b0;
        if (bus.res_valid && !rdy) begin
            n_stall++;
            stall_left--;
        end
        if (bus.res_valid && rdy) begin
            res_q.push_back(cur[24:9]);
            rdat_q.push_back(cur[8:0]);
        end
        prev_stall    = bus.res_valid && !rdy;
        prev_res      = cur;
        bus.res_ready = rdy;
    endtask

    task automatic wait_done(input int base, input bit spam, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (spam && busy) begin
                start       = 1'($urandom_range(1, 0));
                cfg_ke_size = W'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
            if (n_done > base) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic sweep(input int n, input int rm, input bit spam);
        logic [15:0] mp[$];
        int b_en, b_res, b_sent, b_done, b_stall, np;
        bit ok;
        for (int a = 0; a < n; a++)
            for (int b = a + 1; b < n; b++)
                mp.push_back({8'(a), 8'(b)});
        np         = mp.size();
        b_en       = en_q.size();
        b_res      = res_q.size();
        b_sent     = sent_q.size();
        b_done     = n_done;
        b_stall    = n_stall;
        rmode      = rm;
        stall_at   = res_q.size() + 1;
        stall_left = 5;
        cfg_ke_size = W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("terr_clr", 32'(timeout_err), 0);
        wait_done(b_done, spam, ok);
        chk("done_seen", 32'(ok), 1);
        repeat (3) tick();
        chk("done_once", n_done - b_done, 1);
        chk("n_issued", en_q.size() - b_en, np);
        chk("n_results", res_q.size() - b_res, np);
        if (res_q.size() - b_res == np && en_q.size() - b_en == np
            && sent_q.size() - b_sent == np) begin
            for (int k = 0; k < np; k++) begin
                chk("en_pair", 32'(en_q[b_en + k]), 32'(mp[k]));
                chk("res_pair", 32'(res_q[b_res + k]), 32'(mp[k]));
                chk("res_data", 32'(rdat_q[b_res + k]), 32'(sent_q[b_sent + k]));
            end
        end
        chk("pair_cnt", 32'(pair_cnt), np);
        chk("terr_end", 32'(timeout_err), 0);
        chk("busy_end", 32'(busy), 0);
        chk("stall_hold", stall_err, 0);
        if (rm == 2) chk("stall_cyc", n_stall - b_stall, 5);
    endtask

    initial begin
        int  b_done, b_en, b_res, b_clr, s_cyc;
        bit  ok, found;
        reset_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        cfg_ke_size = '0;
        bus.calc_valid = 1'b0;
        bus.calc_dist = '0;
        bus.calc_overflow = 1'b0;
        bus.res_ready = 1'b0;
        rmode = 0;
        lat_lo = 1;
        lat_hi = 1;
        rsp_hang = 1'b0;
        repeat (3) tick();
        chk("rst_ctl", {busy, done, timeout_err, bus.calc_en,
                        bus.calc_clear, bus.res_valid}, 0);
        chk("rst_idx", {bus.calc_idx1, bus.calc_idx2}, 0);
        chk("rst_res", {bus.res_idx1, bus.res_idx2, bus.res_dist,
                        bus.res_overflow}, 0);
        chk("rst_cnt", 32'(pair_cnt), 0);
        reset_n = 1'b1;
        tick();

        // N=4, response two cycles after calc_en, always ready
        sweep(4, 0, 1'b0);

        // N=1: no pairs, done two cycles after start
        b_done = n_done;
        b_en   = en_q.size();
        cfg_ke_size = 8'd1;
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
        wait_done(b_done, 1'b0, ok);
        chk("n1_done", 32'(ok), 1);
        chk("n1_lat", last_done_cyc - s_cyc, 2);
        chk("n1_en", en_q.size() - b_en, 0);
        chk("n1_cnt", 32'(pair_cnt), 0);

        // N=3 with a five-cycle stall on the second result
        sweep(3, 2, 1'b0);

        // Calculator never answers
        rsp_hang = 1'b1;
        b_done = n_done;
        b_en   = en_q.size();
        b_res  = res_q.size();
        cfg_ke_size = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(b_done, 1'b0, ok);
        chk("to_done", 32'(ok), 1);
        chk("to_clr_lat", last_clr_cyc - last_en_cyc, TMO + 1);
        chk("to_err", 32'(timeout_err), 1);
        chk("to_cnt", 32'(pair_cnt), 0);
        chk("to_res", res_q.size() - b_res, 0);
        chk("to_en", en_q.size() - b_en, 1);
        rsp_hang = 1'b0;
        sweep(2, 0, 1'b0);

        // Abort while waiting on pair (1,2)
        lat_lo = 2;
        lat_hi = 2;
        rmode  = 0;
        b_done = n_done;
        cfg_ke_size = 8'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.calc_en && bus.calc_idx1 == 8'd1 && bus.calc_idx2 == 8'd2) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("ab_found", 32'(found), 1);
        tick();
        abort = 1'b1;
        b_clr = n_clr;
        tick();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_clr", 32'(bus.calc_clear), 1);
        repeat (4) tick();
        chk("ab_clr_once", n_clr - b_clr, 1);
        chk("ab_nodone", n_done - b_done, 0);
        chk("ab_cnt", 32'(pair_cnt), 3);
        chk("ab_rv", 32'(bus.res_valid), 0);

        // Random sizes, latencies and backpressure
        lat_lo = 0;
        lat_hi = 3;
        for (int k = 0; k < 6; k++) begin
            sweep($urandom_range(7, 0), 1, 1'b0);
        end

        // Reset while a result is stalled in EMIT
        rmode = 3;
        cfg_ke_size = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.res_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("rs_emit", 32'(found), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rs_ctl", {busy, done, timeout_err, bus.calc_en,
                       bus.calc_clear, bus.res_valid}, 0);
        chk("rs_res", {bus.res_idx1, bus.res_idx2, bus.res_dist,
                       bus.res_overflow}, 0);
        chk("rs_idx", {bus.calc_idx1, bus.calc_idx2}, 0);
        chk("rs_cnt", 32'(pair_cnt), 0);
        tick();
        reset_n = 1'b1;
        tick();
        sweep(4, 1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
